// File: rtl/instr_fetch_rr_arbiter.sv
// Round-robin instruction-fetch arbiter: N_CPU cores share one synchronous ROM.
// Optional per-core lost-arbitration counters are enabled with IFETCH_STALL_CNT_EN.
module instr_fetch_rr_arbiter #(
  parameter int          N_CPU     = 3,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RST_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CPU-1:0]      req,
  input  logic [N_CPU*32-1:0]   pc_flat,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic                  imem_rd_en,
  input  logic [31:0]           imem_rdata,
  output logic [N_CPU-1:0]      grant,
  output logic [N_CPU-1:0]      instr_valid,
  output logic [N_CPU*32-1:0]   instr_flat,
  output logic [N_CPU*32-1:0]   stall_cnt_flat
);

  localparam int PTR_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  logic [PTR_W-1:0]  ptr_reg;
  logic [N_CPU-1:0]  outstanding_reg;
  logic              pend_valid_reg;
  logic [PTR_W-1:0]  pend_id_reg;
  logic [N_CPU-1:0]  instr_valid_reg;

  logic [N_CPU-1:0]  eligible;
  logic              win_found;
  logic [PTR_W-1:0]  win_id;
  logic [PTR_W-1:0]  scan_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic [ADDR_W-1:0] pc_addr [N_CPU];
  logic              unused_pc;

  genvar gi;

  generate
    for (gi = 0; gi < N_CPU; gi++) begin : g_pc
      assign pc_addr[gi] = pc_flat[32*gi+2 +: ADDR_W];
    end
  endgenerate

  assign unused_pc = ^pc_flat;

  // Scan from ptr upwards (mod N_CPU); the first eligible core wins.
  always_comb begin
    eligible  = req & ~outstanding_reg;
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    if (rst) begin
      for (int k = 0; k < N_CPU; k++) begin
        scan_idx = PTR_W'((int'(ptr_reg) + k) % N_CPU);
        if (!win_found && eligible[scan_idx]) begin
          win_found = 1'b1;
          win_id    = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant      = '0;
    imem_rd_en = win_found;
    imem_addr  = '0;
    if (win_found) begin
      grant[win_id] = 1'b1;
      imem_addr     = pc_addr[win_id];
    end
  end

  assign ptr_next = (int'(win_id) == N_CPU - 1) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg         <= '0;
      outstanding_reg <= '0;
      pend_valid_reg  <= 1'b0;
      pend_id_reg     <= '0;
      instr_valid_reg <= '0;
    end else begin
      // A core's clear (its valid pulse) and set (a new grant) can never overlap.
      outstanding_reg <= (outstanding_reg & ~instr_valid_reg) | grant;
      pend_valid_reg  <= win_found;
      if (win_found) begin
        ptr_reg     <= ptr_next;
        pend_id_reg <= win_id;
      end
      instr_valid_reg <= '0;
      if (pend_valid_reg) begin
        instr_valid_reg[pend_id_reg] <= 1'b1;
      end
    end
  end

  assign instr_valid = instr_valid_reg;

  generate
    for (gi = 0; gi < N_CPU; gi++) begin : g_slot
      logic [31:0] slot_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg <= RST_INSTR;
        end else if (pend_valid_reg && pend_id_reg == PTR_W'(gi)) begin
          slot_reg <= imem_rdata;
        end
      end
      assign instr_flat[32*gi +: 32] = slot_reg;
    end
  endgenerate

`ifdef IFETCH_STALL_CNT_EN
  generate
    for (gi = 0; gi < N_CPU; gi++) begin : g_stall
      logic [31:0] cnt_reg;
      // Counts cycles where the core was eligible but another core won.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (req[gi] && !grant[gi] && !outstanding_reg[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign stall_cnt_flat[32*gi +: 32] = cnt_reg;
    end
  endgenerate
`else
  assign stall_cnt_flat = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_rr_arbiter.sv
// Self-checking bench for instr_fetch_rr_arbiter: random and directed stimulus
// against a cycle-count based reference model of the fetch pipeline.
module tb_instr_fetch_rr_arbiter;
  localparam int          N   = 3;
  localparam int          AW  = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*32-1:0] pc_flat;
  logic [AW-1:0]   imem_addr;
  logic            imem_rd_en;
  logic [31:0]     imem_rdata = 32'h0;
  logic [N-1:0]    grant;
  logic [N-1:0]    instr_valid;
  logic [N*32-1:0] instr_flat;
  logic [N*32-1:0] stall_cnt_flat;

  instr_fetch_rr_arbiter #(.N_CPU(N), .ADDR_W(AW), .RST_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .req(req), .pc_flat(pc_flat),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .grant(grant), .instr_valid(instr_valid), .instr_flat(instr_flat),
    .stall_cnt_flat(stall_cnt_flat)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [64];
  always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: each core is busy until a cycle number; completions are a queue.
  typedef struct { int due; int id; logic [31:0] word; } done_t;
  int              m_ptr;
  int              m_ready [N];
  logic [31:0]     m_slot  [N];
  logic [31:0]     m_stall [N];
  done_t           m_q [$];
  int              e_win;
  logic [N-1:0]    e_grant, e_valid;
  logic [AW-1:0]   e_addr;
  logic [N*32-1:0] e_slots, e_stall;
  logic [N*32-1:0] pcs;

  function automatic void model_reset();
    m_ptr = 0;
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_ready[i] = 0; m_slot[i] = NOP; m_stall[i] = 32'h0;
    end
  endfunction

  function automatic void model_begin();
    e_win = -1; e_grant = '0; e_valid = '0; e_addr = '0;
    if (!rst) model_reset();
    else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (e_win < 0 && req[i] && cyc >= m_ready[i]) e_win = i;
      end
      if (e_win >= 0) begin
        e_grant[e_win] = 1'b1;
        e_addr = pc_flat[32*e_win+2 +: AW];
      end
      foreach (m_q[j]) if (m_q[j].due == cyc) begin
        e_valid[m_q[j].id] = 1'b1;
        m_slot[m_q[j].id] = m_q[j].word;
      end
    end
    for (int i = 0; i < N; i++) begin
      e_slots[32*i +: 32] = m_slot[i];
`ifdef IFETCH_STALL_CNT_EN
      e_stall[32*i +: 32] = m_stall[i];
`else
      e_stall[32*i +: 32] = 32'h0;
`endif
    end
  endfunction

  task automatic model_edge();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      for (int i = 0; i < N; i++)
        if (i != e_win && req[i] && cyc >= m_ready[i]) m_stall[i] = m_stall[i] + 32'd1;
      if (e_win >= 0) begin
        m_ptr = (e_win + 1) % N;
        m_ready[e_win] = cyc + 3;
        m_q.push_back('{cyc + 2, e_win, rom[pc_flat[32*e_win+2 +: AW]]});
      end
      while (m_q.size() > 0 && m_q[0].due <= cyc) void'(m_q.pop_front());
    end
    cyc++;
  endtask

  task automatic drive(input logic r_rst, input logic [N-1:0] r_req, input logic [N*32-1:0] r_pc);
    @(negedge clk);
    rst = r_rst; req = r_req; pc_flat = r_pc;
    #1;
    model_begin();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      drive(1'b1, '0, pcs); model_edge();
    end
  endtask

  function automatic logic [N*32-1:0] rand_pcs();
    logic [N*32-1:0] p;
    for (int i = 0; i < N; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  task automatic test_reset();
    pcs = rand_pcs();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 3'b111, pcs);
      total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant); end
      total++; if (imem_rd_en !== 1'b0 || imem_addr !== '0) begin bad++; $display("FAIL reset_rom got en=%b addr=%0d exp en=0 addr=0", imem_rd_en, imem_addr); end
      total++; if (instr_valid !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b exp=000", instr_valid); end
      total++; if (instr_flat !== {N{NOP}}) begin bad++; $display("FAIL reset_slots got=%h exp=%h", instr_flat, {N{NOP}}); end
      total++; if (stall_cnt_flat !== '0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall_cnt_flat); end
      model_edge();
    end
    drive(1'b1, 3'b111, pcs);
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b exp=001", grant); end
    model_edge();
    idle(3);
  endtask

  task automatic test_single();
    rom[2] = 32'hDEADBEEF;
    pcs = rand_pcs(); pcs[63:32] = 32'h0000_0008;
    drive(1'b1, 3'b010, pcs);
    total++; if (grant !== 3'b010 || imem_addr !== 6'd2 || imem_rd_en !== 1'b1) begin
      bad++; $display("FAIL single_issue got grant=%b addr=%0d en=%b exp 010/2/1", grant, imem_addr, imem_rd_en); end
    model_edge();
    pcs[63:32] = 32'h0000_0040;
    drive(1'b1, 3'b010, pcs);
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL single_busy got=%b exp=000", grant); end
    model_edge();
    drive(1'b1, 3'b010, pcs);
    total++; if (instr_valid !== 3'b010) begin bad++; $display("FAIL single_valid got=%b exp=010", instr_valid); end
    total++; if (instr_flat[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_word got=%h exp=deadbeef", instr_flat[63:32]); end
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL single_busy2 got=%b exp=000", grant); end
    model_edge();
    drive(1'b1, 3'b010, pcs);
    total++; if (grant !== 3'b010) begin bad++; $display("FAIL single_regrant got=%b exp=010", grant); end
    total++; if (instr_valid !== 3'b000) begin bad++; $display("FAIL single_pulse_len got=%b exp=000", instr_valid); end
    model_edge();
    idle(3);
  endtask

  task automatic test_back_to_back();
    pcs = rand_pcs();
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 3'b111, pcs);
      total++; if (grant !== e_grant || imem_addr !== e_addr) begin
        bad++; $display("FAIL b2b_grant c=%0d got=%b/%0d exp=%b/%0d", c, grant, imem_addr, e_grant, e_addr); end
      total++; if (instr_valid !== e_valid) begin bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, instr_valid, e_valid); end
      total++; if (instr_flat !== e_slots) begin bad++; $display("FAIL b2b_slots c=%0d got=%h exp=%h", c, instr_flat, e_slots); end
      model_edge();
    end
    idle(3);
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'b010, pcs); model_edge();
    idle(3);
    drive(1'b1, 3'b011, pcs);
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL wrap_grant got=%b exp=001", grant); end
    model_edge();
    idle(3);
  endtask

  task automatic test_midreset();
    drive(1'b1, 3'b010, pcs);
    total++; if (grant !== 3'b010) begin bad++; $display("FAIL midrst_grant got=%b exp=010", grant); end
    model_edge();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 3'b010, pcs);
      total++; if (instr_valid !== 3'b000) begin bad++; $display("FAIL midrst_valid_in c=%0d got=%b exp=000", c, instr_valid); end
      model_edge();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 3'b000, pcs);
      total++; if (instr_valid !== 3'b000) begin bad++; $display("FAIL midrst_valid_after c=%0d got=%b exp=000", c, instr_valid); end
      total++; if (instr_flat[63:32] !== NOP) begin bad++; $display("FAIL midrst_slot c=%0d got=%h exp=%h", c, instr_flat[63:32], NOP); end
      model_edge();
    end
    drive(1'b1, 3'b111, pcs);
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL midrst_ptr got=%b exp=001", grant); end
    model_edge();
    idle(3);
  endtask

  task automatic test_stall();
    drive(1'b0, 3'b000, pcs); model_edge();
    drive(1'b0, 3'b000, pcs); model_edge();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 3'b111, pcs);
      total++; if (stall_cnt_flat !== e_stall) begin bad++; $display("FAIL stall_run c=%0d got=%h exp=%h", c, stall_cnt_flat, e_stall); end
      model_edge();
    end
    drive(1'b1, 3'b000, pcs);
    total++; if (stall_cnt_flat !== e_stall) begin bad++; $display("FAIL stall_final got=%h exp=%h", stall_cnt_flat, e_stall); end
    model_edge();
    idle(3);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) pcs = rand_pcs();
      drive(($urandom_range(0, 79) != 0), N'($urandom), pcs);
      total++; if (grant !== e_grant) begin bad++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, grant, e_grant); end
      total++; if (imem_rd_en !== (e_win >= 0) || imem_addr !== e_addr) begin
        bad++; $display("FAIL rand_rom c=%0d got=%b/%0d exp=%b/%0d", c, imem_rd_en, imem_addr, (e_win >= 0), e_addr); end
      total++; if (instr_valid !== e_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, instr_valid, e_valid); end
      total++; if (instr_flat !== e_slots) begin bad++; $display("FAIL rand_slots c=%0d got=%h exp=%h", c, instr_flat, e_slots); end
      total++; if (stall_cnt_flat !== e_stall) begin bad++; $display("FAIL rand_stall c=%0d got=%h exp=%h", c, stall_cnt_flat, e_stall); end
      model_edge();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rst = 1'b0; req = '0; pc_flat = '0; pcs = '0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_midreset();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
